// File: rtl/mmio_seq_pkg.sv
// mmio_seq_pkg
//   Shared types for mmio_bus_sequencer: the command opcode encoding seen on
//   cmd_op and the sequencer state enumeration.
package mmio_seq_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_POLL  = 2'd2,
    OP_WAIT  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_IDLE,
    ST_WR_STB,
    ST_RD_STB,
    ST_RD_SMP,
    ST_POLL_GAP,
    ST_WAIT
  } state_e;

endpackage

// File: rtl/mmio_bus_sequencer.sv
// mmio_bus_sequencer
//   CPU-side bus master for memory-mapped peripherals. After reset it holds
//   periph_reset high for RESET_HOLD cycles, then executes one command at a
//   time from a valid/ready port: WRITE, READ, POLL-until-match with a bounded
//   number of read attempts, and WAIT. Every access is a single-cycle
//   active-low cs/rd/wr strobe; all bus outputs are registered.
//
// Ports
//   clock, reset          system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_op                0=WRITE 1=READ 2=POLL 3=WAIT
//   cmd_addr              register address
//   cmd_data              WRITE data / POLL mask / WAIT cycle count
//   cmd_cmp               POLL compare value
//   rsp_valid             one-cycle completion pulse
//   rsp_data              last sampled read data
//   rsp_timeout           POLL ended without a match (qualified by rsp_valid)
//   periph_reset          active-high reset to the peripheral
//   cs, rd, wr            active-low bus strobes
//   addr, bus_wdata       bus address and write data
//   bus_rdata             read data, valid the cycle after the rd strobe
module mmio_bus_sequencer
  import mmio_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 3,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned RESET_HOLD   = 16,
  parameter int unsigned POLL_TIMEOUT = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [DATA_WIDTH-1:0] cmd_cmp,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_timeout,
  output logic                  periph_reset,
  output logic                  cs,
  output logic                  rd,
  output logic                  wr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam int unsigned ATT_W  = $clog2(POLL_TIMEOUT + 1);
  localparam int unsigned HOLD_W = $clog2(RESET_HOLD + 1);

  state_e                state_q, state_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [ATT_W-1:0]      att_q, att_d;
  logic [DATA_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  op_e                   op_q, op_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] cmp_q, cmp_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  cs_q, cs_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  periph_reset_q, periph_reset_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic poll_match;
  assign poll_match = ((bus_rdata & mask_q) == cmp_q);

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    att_d         = att_q;
    wait_cnt_d    = wait_cnt_q;
    op_d          = op_q;
    mask_d        = mask_q;
    cmp_d         = cmp_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rsp_data_d    = rsp_data_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;

    unique case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_W'(RESET_HOLD)) begin
          state_d = ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d   = op_e'(cmd_op);
          mask_d = cmd_data;
          cmp_d  = cmd_cmp;
          unique case (op_e'(cmd_op))
            OP_WRITE: begin
              addr_d  = cmd_addr;
              wdata_d = cmd_data;
              state_d = ST_WR_STB;
            end
            OP_READ: begin
              addr_d  = cmd_addr;
              state_d = ST_RD_STB;
            end
            OP_POLL: begin
              addr_d  = cmd_addr;
              att_d   = ATT_W'(1);
              state_d = ST_RD_STB;
            end
            OP_WAIT: begin
              // A zero count still spends one cycle in WAIT.
              wait_cnt_d = (cmd_data == '0) ? DATA_WIDTH'(1) : cmd_data;
              state_d    = ST_WAIT;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end

      ST_WR_STB: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b1;
      end

      ST_RD_STB: begin
        state_d = ST_RD_SMP;
      end

      ST_RD_SMP: begin
        rsp_data_d = bus_rdata;
        if (op_q != OP_POLL || poll_match) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
        end else if (att_q == ATT_W'(POLL_TIMEOUT)) begin
          state_d       = ST_IDLE;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          state_d = ST_POLL_GAP;
        end
      end

      ST_POLL_GAP: begin
        att_d   = att_q + ATT_W'(1);
        state_d = ST_RD_STB;
      end

      ST_WAIT: begin
        if (wait_cnt_q <= DATA_WIDTH'(1)) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - DATA_WIDTH'(1);
        end
      end

      default: state_d = ST_HOLD;
    endcase

    // Bus-facing outputs are decoded from the next state so that they are
    // registered and line up with the cycle the state is occupied.
    cs_d           = !(state_d == ST_WR_STB || state_d == ST_RD_STB);
    wr_d           = (state_d != ST_WR_STB);
    rd_d           = (state_d != ST_RD_STB);
    periph_reset_d = (state_d == ST_HOLD);
    cmd_ready_d    = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_HOLD;
      hold_cnt_q     <= '0;
      att_q          <= '0;
      wait_cnt_q     <= '0;
      op_q           <= OP_WRITE;
      mask_q         <= '0;
      cmp_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      cs_q           <= 1'b1;
      rd_q           <= 1'b1;
      wr_q           <= 1'b1;
      periph_reset_q <= 1'b1;
      cmd_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      att_q          <= att_d;
      wait_cnt_q     <= wait_cnt_d;
      op_q           <= op_d;
      mask_q         <= mask_d;
      cmp_q          <= cmp_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      cs_q           <= cs_d;
      rd_q           <= rd_d;
      wr_q           <= wr_d;
      periph_reset_q <= periph_reset_d;
      cmd_ready_q    <= cmd_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_timeout_q  <= rsp_timeout_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign periph_reset = periph_reset_q;
  assign cs           = cs_q;
  assign rd           = rd_q;
  assign wr           = wr_q;
  assign addr         = addr_q;
  assign bus_wdata    = wdata_q;

endmodule

// File: tb/tb_mmio_bus_sequencer.sv
// tb_mmio_bus_sequencer
//   Directed and randomized checks of mmio_bus_sequencer against a
//   transaction-level model: each command's expected strobes, completion
//   cycle and response fields are computed from the command and the data the
//   bench's peripheral returns.
module tb_mmio_bus_sequencer;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned RH = 16;
  localparam int unsigned PT = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [DW-1:0] cmd_cmp = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_timeout;
  logic          periph_reset;
  logic          cs, rd, wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata = '0;

  mmio_bus_sequencer #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .RESET_HOLD  (RH),
    .POLL_TIMEOUT(PT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_cmp     (cmd_cmp),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .periph_reset(periph_reset),
    .cs          (cs),
    .rd          (rd),
    .wr          (wr),
    .addr        (addr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int unsigned   cyc;
    logic          cs;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } strobe_t;

  strobe_t       sq[$];
  int unsigned   rsp_cyc[$];
  logic [DW-1:0] rsp_dat[$];
  logic          rsp_to[$];
  logic [DW-1:0] rdq[$];
  logic [DW-1:0] vals[$];

  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rsp_data = '0;

  // Bus monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (!cs || !rd || !wr) sq.push_back('{cyc, cs, rd, wr, addr, bus_wdata});
    if (rsp_valid) begin
      rsp_cyc.push_back(cyc);
      rsp_dat.push_back(rsp_data);
      rsp_to.push_back(rsp_timeout);
    end
  end

  // Peripheral: answers each rd strobe with the next queued value on the
  // following cycle; every other cycle the read bus carries junk.
  always @(posedge clock) begin
    if (!cs && !rd && rdq.size() > 0) bus_rdata <= rdq.pop_front();
    else                              bus_rdata <= DW'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic hold_check(input int unsigned r0);
    int unsigned hi = 0, bad = 0, first = 0;
    for (int n = 0; n < 40 && first == 0; n++) begin
      tick();
      if (periph_reset) hi++;
      if (!cs || !rd || !wr || rsp_valid) bad++;
      if (cmd_ready) first = cyc;
    end
    chk("first_cmd_ready_cycle", first - r0, RH + 1);
    chk("periph_reset_hold_cycles", hi, RH);
    chk("activity_during_hold", bad, 0);
    chk("periph_reset_released", periph_reset, 0);
  endtask

  // Returns t such that the acceptance edge ends cycle t (strobes in t+1).
  task automatic accept(input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] c,
                        output int unsigned t);
    int unsigned n = 0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    chk("cmd_ready_before_issue", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_cmp   = c;
    @(posedge clock);
    #1;
    t = cyc - 1;
    sq.delete();
    rsp_cyc.delete();
    rsp_dat.delete();
    rsp_to.delete();
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] c);
    strobe_t       e[$];
    int unsigned   t, exp_rsp, k, n;
    logic          exp_to;
    logic [DW-1:0] exp_dat;
    exp_to  = 1'b0;
    exp_dat = m_rsp_data;
    exp_rsp = 0;
    case (op)
      2'd0: begin
        e.push_back('{1, 1'b0, 1'b1, 1'b0, a, d});
        exp_rsp = 2;
      end
      2'd1: begin
        e.push_back('{1, 1'b0, 1'b0, 1'b1, a, m_wdata});
        exp_rsp = 3;
        exp_dat = vals[0];
      end
      2'd2: begin
        k = 0;
        for (int unsigned i = 1; i <= PT; i++) begin
          e.push_back('{3 * i - 2, 1'b0, 1'b0, 1'b1, a, m_wdata});
          if ((vals[i-1] & d) == c) begin
            k = i;
            break;
          end
        end
        if (k != 0) begin
          exp_rsp = 3 * k;
          exp_dat = vals[k-1];
        end else begin
          exp_rsp = 3 * PT;
          exp_dat = vals[PT-1];
          exp_to  = 1'b1;
        end
      end
      default: exp_rsp = (d == '0) ? 32'd2 : 32'(d) + 32'd1;
    endcase

    rdq = vals;
    accept(op, a, d, c, t);
    // Offer junk commands while busy; they must be ignored.
    cmd_valid = 1'b1;
    cmd_op    = 2'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_data  = DW'($urandom);
    n = 0;
    while (rsp_cyc.size() == 0 && n < exp_rsp + 20) begin
      tick();
      n++;
    end
    cmd_valid = 1'b0;

    chk("rsp_count", rsp_cyc.size(), 1);
    if (rsp_cyc.size() > 0) begin
      chk("rsp_cycle", rsp_cyc[0] - t, exp_rsp);
      chk("rsp_data", rsp_dat[0], exp_dat);
      chk("rsp_timeout", rsp_to[0], exp_to);
    end
    chk("strobe_count", sq.size(), e.size());
    for (int i = 0; i < e.size() && i < sq.size(); i++) begin
      chk("strobe_cycle", sq[i].cyc - t, e[i].cyc);
      chk("strobe_cs", sq[i].cs, e[i].cs);
      chk("strobe_rd", sq[i].rd, e[i].rd);
      chk("strobe_wr", sq[i].wr, e[i].wr);
      chk("strobe_addr", sq[i].addr, e[i].addr);
      chk("strobe_wdata", sq[i].wdata, e[i].wdata);
    end

    if (op == 2'd0) m_wdata = d;
    if (op == 2'd1 || op == 2'd2) m_rsp_data = exp_dat;
    rdq.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned   r0, t, n;
    logic [1:0]    op;
    logic [AW-1:0] a;
    logic [DW-1:0] d, c, v;

    // Reset state
    tick();
    chk("reset_periph_reset", periph_reset, 1);
    chk("reset_cs", cs, 1);
    chk("reset_rd", rd, 1);
    chk("reset_wr", wr, 1);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_timeout", rsp_timeout, 0);
    chk("reset_addr", addr, 0);
    chk("reset_bus_wdata", bus_wdata, 0);
    tick();
    reset = 1'b0;
    r0 = cyc;
    hold_check(r0);

    // Directed commands
    vals.delete();
    run_cmd(2'd0, 3'd3, 8'hA5, 8'h00);
    vals = '{8'h3C};
    run_cmd(2'd1, 3'd5, 8'h00, 8'h00);
    vals = '{8'h00, 8'hFE, 8'h01, 8'h01};
    run_cmd(2'd2, 3'd5, 8'h01, 8'h01);
    vals = '{8'h00, 8'h02, 8'hFE, 8'h10};
    run_cmd(2'd2, 3'd5, 8'h01, 8'h01);
    vals.delete();
    run_cmd(2'd3, 3'd0, 8'd0, 8'h00);
    run_cmd(2'd3, 3'd0, 8'd5, 8'h00);
    vals = '{8'h81};
    run_cmd(2'd1, 3'd7, 8'h00, 8'h00);
    vals.delete();
    run_cmd(2'd3, 3'd2, 8'd1, 8'h00);

    // Reset in the middle of a POLL read strobe
    vals = '{8'h00, 8'h00, 8'h00, 8'h00};
    rdq = vals;
    accept(2'd2, 3'd5, 8'h01, 8'h01, t);
    n = 0;
    while (rd && n < 20) begin
      tick();
      n++;
    end
    chk("midop_rd_strobe_seen", rd, 0);
    reset = 1'b1;
    #1;
    chk("midop_reset_cs", cs, 1);
    chk("midop_reset_rd", rd, 1);
    chk("midop_reset_periph_reset", periph_reset, 1);
    chk("midop_reset_rsp_valid", rsp_valid, 0);
    tick();
    tick();
    reset = 1'b0;
    r0 = cyc;
    hold_check(r0);
    chk("midop_dropped_rsp", rsp_cyc.size(), 0);
    rdq.delete();
    m_wdata    = '0;
    m_rsp_data = '0;
    vals.delete();
    run_cmd(2'd0, 3'd3, 8'h5A, 8'h00);

    // Randomized commands
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = AW'($urandom);
      d  = DW'($urandom);
      c  = DW'($urandom);
      vals.delete();
      if (op == 2'd3) d = DW'($urandom_range(0, 9));
      if (op == 2'd1) vals.push_back(DW'($urandom));
      if (op == 2'd2) begin
        if ($urandom_range(0, 3) != 0) c = c & d;
        for (int j = 0; j < PT; j++) begin
          v = DW'($urandom);
          if ($urandom_range(0, 2) == 0) v = (v & ~d) | (c & d);
          vals.push_back(v);
        end
      end
      run_cmd(op, a, d, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
